// File: rtl/tlc_pkg.sv
// Shared types for the traffic-light controller family: signal-head
// encoding, phase scheduler states and served-phase identifiers.
package tlc_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;

    typedef enum logic [2:0] {
        SC_HOLD    = 3'd0,
        SC_GRN     = 3'd1,
        SC_YEL     = 3'd2,
        SC_ALL_RED = 3'd3,
        SC_WALK    = 3'd4
    } sched_state_t;

    typedef enum logic [1:0] {
        PH_NS  = 2'd0,
        PH_EW  = 2'd1,
        PH_PED = 2'd2
    } phase_t;

    // One-hot position of a phase inside the request/pending/grant vectors.
    function automatic logic [2:0] phase_mask(input phase_t p);
        case (p)
            PH_NS:   return 3'b001;
            PH_EW:   return 3'b010;
            PH_PED:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Combinational 3-way round-robin picker. Search starts at the phase after
// the last served one, in the order NS -> EW -> PED -> NS.
module tlc_rr_pick
    import tlc_pkg::*;
(
    input  logic [2:0] pending_i,
    input  phase_t     last_i,
    output logic       valid_o,
    output phase_t     pick_o
);

    // Priority rotates so the most recently served phase is checked last.
    always_comb begin
        valid_o = |pending_i;
        pick_o  = PH_NS;
        case (last_i)
            PH_NS: begin
                if (pending_i[1])      pick_o = PH_EW;
                else if (pending_i[2]) pick_o = PH_PED;
                else                   pick_o = PH_NS;
            end
            PH_EW: begin
                if (pending_i[2])      pick_o = PH_PED;
                else if (pending_i[0]) pick_o = PH_NS;
                else                   pick_o = PH_EW;
            end
            default: begin
                if (pending_i[0])      pick_o = PH_NS;
                else if (pending_i[1]) pick_o = PH_EW;
                else                   pick_o = PH_PED;
            end
        endcase
    end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Demand-actuated phase scheduler: latches NS/EW/PED requests, serves them
// round-robin and sequences green, yellow, all-red and walk intervals.
// Every output is a register loaded from the next-state decode, so no
// request input reaches an output combinationally.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int unsigned GRN_MIN  = 20,
    parameter int unsigned GRN_MAX  = 50,
    parameter int unsigned YEL_T    = 10,
    parameter int unsigned ALLRED_T = 5,
    parameter int unsigned WALK_T   = 30,
    parameter int unsigned CNT_W    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ns_req,
    input  logic         ew_req,
    input  logic         ped_req,
    output light_t       NS_light,
    output light_t       EW_light,
    output logic         walk,
    output logic [2:0]   gnt,
    output sched_state_t dbg_state
);

    localparam logic [CNT_W-1:0] GRN_MIN_C = CNT_W'(GRN_MIN - 1);
    localparam logic [CNT_W-1:0] GRN_MAX_C = CNT_W'(GRN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_C     = CNT_W'(YEL_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_C  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_C    = CNT_W'(WALK_T - 1);

    sched_state_t     state_q, state_d;
    phase_t           ph_q, ph_d;
    phase_t           last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pend_q, pend_d;
    light_t           ns_q, ns_d;
    light_t           ew_q, ew_d;
    logic             walk_q, walk_d;
    logic [2:0]       gnt_q, gnt_d;

    logic [2:0]       req_v;
    logic [2:0]       act_mask;
    logic [2:0]       enter_mask;
    logic             own_req;
    logic             other_pend;
    logic             pick_valid;
    phase_t           pick;

    tlc_rr_pick u_pick (
        .pending_i (pend_q),
        .last_i    (last_q),
        .valid_o   (pick_valid),
        .pick_o    (pick)
    );

    // Next-state, pending-latch, interval-counter and output decode.
    always_comb begin
        req_v      = {ped_req, ew_req, ns_req};
        state_d    = state_q;
        ph_d       = ph_q;
        last_d     = last_q;
        enter_mask = 3'b000;
        act_mask   = 3'b000;
        own_req    = (ph_q == PH_EW) ? ew_req : ns_req;
        other_pend = |(pend_q & ~phase_mask(ph_q));

        // A phase being served does not re-latch its own request.
        case (state_q)
            SC_GRN, SC_YEL: act_mask = phase_mask(ph_q);
            SC_WALK:        act_mask = 3'b100;
            default:        act_mask = 3'b000;
        endcase

        case (state_q)
            SC_HOLD: begin
                if (pick_valid) enter_mask = phase_mask(pick);
            end
            SC_GRN: begin
                if (other_pend && (cnt_q >= GRN_MIN_C) &&
                    (!own_req || (cnt_q >= GRN_MAX_C)))
                    state_d = SC_YEL;
            end
            SC_YEL: begin
                if (cnt_q == YEL_C) state_d = SC_ALL_RED;
            end
            SC_WALK: begin
                if (cnt_q == WALK_C) state_d = SC_ALL_RED;
            end
            SC_ALL_RED: begin
                if (cnt_q == ALLRED_C) begin
                    if (pick_valid) enter_mask = phase_mask(pick);
                    else            state_d    = SC_HOLD;
                end
            end
            default: state_d = SC_HOLD;
        endcase

        if (enter_mask != 3'b000) begin
            state_d = (pick == PH_PED) ? SC_WALK : SC_GRN;
            ph_d    = pick;
            last_d  = pick;
        end

        // Clear on entry wins over a same-edge set.
        pend_d = (pend_q | (req_v & ~act_mask)) & ~enter_mask;

        if (state_d != state_q) cnt_d = '0;
        else if (&cnt_q)        cnt_d = cnt_q;
        else                    cnt_d = cnt_q + 1'b1;

        ns_d = RED;
        ew_d = RED;
        if (state_d == SC_GRN) begin
            if (ph_d == PH_EW) ew_d = GREEN;
            else               ns_d = GREEN;
        end else if (state_d == SC_YEL) begin
            if (ph_d == PH_EW) ew_d = YELLOW;
            else               ns_d = YELLOW;
        end
        walk_d = (state_d == SC_WALK);
        gnt_d  = enter_mask;
    end

    // Scheduler state and registered signal-head outputs; reset is immediate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SC_HOLD;
            ph_q    <= PH_NS;
            last_q  <= PH_PED;
            cnt_q   <= '0;
            pend_q  <= 3'b000;
            ns_q    <= RED;
            ew_q    <= RED;
            walk_q  <= 1'b0;
            gnt_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ns_q    <= ns_d;
            ew_q    <= ew_d;
            walk_q  <= walk_d;
            gnt_q   <= gnt_d;
        end
    end

    assign NS_light  = ns_q;
    assign EW_light  = ew_q;
    assign walk      = walk_q;
    assign gnt       = gnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Bench for tlc_phase_scheduler: grant scoreboard keyed by cycle number,
// table-driven light/state checkpoints, and hand-written reset sequences.
module tb_tlc_phase_scheduler;
  import tlc_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ns_req = 1'b0;
  logic         ew_req = 1'b0;
  logic         ped_req = 1'b0;
  light_t       ns_l;
  light_t       ew_l;
  logic         walk;
  logic [2:0]   gnt;
  sched_state_t st;

  tlc_phase_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ns_req    (ns_req),
    .ew_req    (ew_req),
    .ped_req   (ped_req),
    .NS_light  (ns_l),
    .EW_light  (ew_l),
    .walk      (walk),
    .gnt       (gnt),
    .dbg_state (st)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_pass = 0;
  int viol = 0;

  // scoreboard entries: {cycle[15:0], grant[2:0]}
  logic [18:0] exp_q[$];
  logic [18:0] sb_e;

  typedef struct {
    int           off;
    light_t       ns;
    light_t       ew;
    logic         wk;
    sched_state_t st;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push_gnt(input int c, input logic [2:0] g);
    exp_q.push_back({16'(c), g});
  endtask

  task automatic do_reset();
    check("sb_drained", exp_q.size(), 0);
    exp_q.delete();
    ns_req = 1'b0;
    ew_req = 1'b0;
    ped_req = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string name, input int g);
    foreach (tbl[i]) begin
      wait_cyc(g + tbl[i].off);
      check($sformatf("%s@%0d.ns", name, tbl[i].off), int'(ns_l), int'(tbl[i].ns));
      check($sformatf("%s@%0d.ew", name, tbl[i].off), int'(ew_l), int'(tbl[i].ew));
      check($sformatf("%s@%0d.walk", name, tbl[i].off), int'(walk), int'(tbl[i].wk));
      check($sformatf("%s@%0d.state", name, tbl[i].off), int'(st), int'(tbl[i].st));
    end
  endtask

  // grant monitor (scoreboard pop) and safety invariant
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt != 3'b000) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL gnt_unexpected: got %b at cycle %0d, none expected", gnt, cyc);
        end else begin
          sb_e = exp_q.pop_front();
          if (sb_e == {cyc[15:0], gnt}) n_pass++;
          else $display("FAIL gnt_seq: got %b at cycle %0d expected %b at cycle %0d",
                        gnt, cyc, sb_e[2:0], sb_e[18:3]);
        end
      end
      if ((ns_l != RED && ew_l != RED) || (walk && (ns_l != RED || ew_l != RED))) viol++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int g;
    int r;
    int bad;

    // reset state
    tick();
    tick();
    check("rst.ns", int'(ns_l), int'(RED));
    check("rst.ew", int'(ew_l), int'(RED));
    check("rst.walk", int'(walk), 0);
    check("rst.gnt", int'(gnt), 0);
    check("rst.state", int'(st), int'(SC_HOLD));
    rst_n = 1'b1;
    r = cyc;

    // 1: idle for 100 cycles
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ns_l != RED || ew_l != RED || walk || gnt != 3'b000) bad++;
    end
    check("t1_idle_bad_cycles", bad, 0);

    // 2: single NS pulse, then NS rests green
    do_reset();
    r = cyc;
    wait_cyc(r + 3);
    ns_req = 1'b1;
    k = cyc;
    g = k + 2;
    push_gnt(g, 3'b001);
    tick();
    ns_req = 1'b0;
    wait_cyc(g);
    check("t2_ns_green", int'(ns_l), int'(GREEN));
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ns_l != GREEN || ew_l != RED || st != SC_GRN) bad++;
    end
    check("t2_rest_bad_cycles", bad, 0);

    // 3: EW pulse at NS c=5 -> min green, yellow, all-red, EW green
    do_reset();
    ns_req = 1'b1;
    k = cyc;
    g = k + 2;
    push_gnt(g, 3'b001);
    tick();
    ns_req = 1'b0;
    wait_cyc(g + 5);
    ew_req = 1'b1;
    push_gnt(g + 35, 3'b010);
    tick();
    ew_req = 1'b0;
    tbl = '{
      '{19, GREEN,  RED,   1'b0, SC_GRN},
      '{20, YELLOW, RED,   1'b0, SC_YEL},
      '{29, YELLOW, RED,   1'b0, SC_YEL},
      '{30, RED,    RED,   1'b0, SC_ALL_RED},
      '{34, RED,    RED,   1'b0, SC_ALL_RED},
      '{35, RED,    GREEN, 1'b0, SC_GRN}
    };
    run_table("t3", g);
    wait_cyc(g + 37);

    // 4a: NS held, EW pending -> green capped at max
    do_reset();
    ns_req = 1'b1;
    k = cyc;
    g = k + 2;
    push_gnt(g, 3'b001);
    wait_cyc(g);
    ew_req = 1'b1;
    tick();
    ew_req = 1'b0;
    tbl = '{
      '{49, GREEN,  RED, 1'b0, SC_GRN},
      '{50, YELLOW, RED, 1'b0, SC_YEL}
    };
    run_table("t4a", g);

    // 4b: NS dropped at c=30 -> green is 31 cycles
    do_reset();
    ns_req = 1'b1;
    k = cyc;
    g = k + 2;
    push_gnt(g, 3'b001);
    wait_cyc(g);
    ew_req = 1'b1;
    push_gnt(g + 46, 3'b010);
    tick();
    ew_req = 1'b0;
    wait_cyc(g + 30);
    ns_req = 1'b0;
    tbl = '{
      '{31, YELLOW, RED,   1'b0, SC_YEL},
      '{46, RED,    GREEN, 1'b0, SC_GRN}
    };
    run_table("t4b", g);
    wait_cyc(g + 48);

    // 5: all three requests together -> NS, EW, PED in turn, then hold
    do_reset();
    ns_req = 1'b1;
    ew_req = 1'b1;
    ped_req = 1'b1;
    k = cyc;
    g = k + 2;
    push_gnt(g, 3'b001);
    push_gnt(g + 35, 3'b010);
    push_gnt(g + 70, 3'b100);
    tick();
    ns_req = 1'b0;
    ew_req = 1'b0;
    ped_req = 1'b0;
    tbl = '{
      '{0,   GREEN,  RED,    1'b0, SC_GRN},
      '{20,  YELLOW, RED,    1'b0, SC_YEL},
      '{35,  RED,    GREEN,  1'b0, SC_GRN},
      '{55,  RED,    YELLOW, 1'b0, SC_YEL},
      '{70,  RED,    RED,    1'b1, SC_WALK},
      '{99,  RED,    RED,    1'b1, SC_WALK},
      '{100, RED,    RED,    1'b0, SC_ALL_RED},
      '{104, RED,    RED,    1'b0, SC_ALL_RED},
      '{105, RED,    RED,    1'b0, SC_HOLD},
      '{130, RED,    RED,    1'b0, SC_HOLD}
    };
    run_table("t5", g);

    // 6: reset mid-yellow with EW pending, then NS served first
    do_reset();
    ns_req = 1'b1;
    ew_req = 1'b1;
    k = cyc;
    g = k + 2;
    push_gnt(g, 3'b001);
    tick();
    ns_req = 1'b0;
    ew_req = 1'b0;
    wait_cyc(g + 24);
    check("t6_pre_state", int'(st), int'(SC_YEL));
    check("t6_pre_ns", int'(ns_l), int'(YELLOW));
    check("t6_sb_drained", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("t6_async.ns", int'(ns_l), int'(RED));
    check("t6_async.ew", int'(ew_l), int'(RED));
    check("t6_async.walk", int'(walk), 0);
    check("t6_async.state", int'(st), int'(SC_HOLD));
    tick();
    tick();
    rst_n = 1'b1;
    ns_req = 1'b1;
    r = cyc;
    push_gnt(r + 2, 3'b001);
    tick();
    ns_req = 1'b0;
    wait_cyc(r + 60);
    check("t6_ns_rests.ns", int'(ns_l), int'(GREEN));
    check("t6_ns_rests.ew", int'(ew_l), int'(RED));
    check("t6_ns_rests.state", int'(st), int'(SC_GRN));

    tick();
    check("sb_drained_final", exp_q.size(), 0);
    check("safety_violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
